serial_display_rx: RTL

Receiving end of the clock's 7-segment serial display link: samples the serial data/clock/latch lines driven by the display shift-out logic, deserializes one frame per latch pulse, and decodes each segment byte back to a BCD digit plus decimal point. Used as the on-chip loopback/self-check monitor and as the display model in top-level benches. All logic runs in the `i_clk` domain; the serial lines are treated as asynchronous inputs.

---
 rtl/display_pkg.sv | 33 +++
 rtl/seg7_decode.sv | 36 +++
 rtl/serial_display_rx.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/display_pkg.sv
// Shared definitions for the 7-segment serial display link.
// Segment byte layout is {dp, g, f, e, d, c, b, a}, active-high.
// Contents: segment pattern constants, decoded digit codes for blank and
// error, byte-format bit positions.
package display_pkg;

  localparam int SEG_BITS = 7;

  localparam int BIT_A  = 0;
  localparam int BIT_B  = 1;
  localparam int BIT_C  = 2;
  localparam int BIT_D  = 3;
  localparam int BIT_E  = 4;
  localparam int BIT_F  = 5;
  localparam int BIT_G  = 6;
  localparam int BIT_DP = 7;

  localparam logic [SEG_BITS-1:0] SEG_0     = 7'h3F;
  localparam logic [SEG_BITS-1:0] SEG_1     = 7'h06;
  localparam logic [SEG_BITS-1:0] SEG_2     = 7'h5B;
  localparam logic [SEG_BITS-1:0] SEG_3     = 7'h4F;
  localparam logic [SEG_BITS-1:0] SEG_4     = 7'h66;
  localparam logic [SEG_BITS-1:0] SEG_5     = 7'h6D;
  localparam logic [SEG_BITS-1:0] SEG_6     = 7'h7D;
  localparam logic [SEG_BITS-1:0] SEG_7     = 7'h07;
  localparam logic [SEG_BITS-1:0] SEG_8     = 7'h7F;
  localparam logic [SEG_BITS-1:0] SEG_9     = 7'h6F;
  localparam logic [SEG_BITS-1:0] SEG_BLANK = 7'h00;

  localparam logic [3:0] DIGIT_BLANK = 4'hF;
  localparam logic [3:0] DIGIT_ERR   = 4'hE;

endpackage

// File: rtl/seg7_decode.sv
// Combinational 7-segment to BCD decoder.
// Ports:
//   seg_i   [6:0] segment bits {g,f,e,d,c,b,a}
//   digit_o [3:0] BCD digit, DIGIT_BLANK for an all-off pattern,
//                 DIGIT_ERR for anything unrecognised
//   err_o         high when the pattern is not a legal digit or blank
// Only the canonical pattern per digit is accepted (9 must include
// segment d), so near-miss encodings are flagged rather than guessed.
module seg7_decode
  import display_pkg::*;
(
  input  logic [SEG_BITS-1:0] seg_i,
  output logic [3:0]          digit_o,
  output logic                err_o
);

  always_comb begin
    digit_o = DIGIT_ERR;
    err_o   = 1'b1;
    case (seg_i)
      SEG_0:     begin digit_o = 4'd0;        err_o = 1'b0; end
      SEG_1:     begin digit_o = 4'd1;        err_o = 1'b0; end
      SEG_2:     begin digit_o = 4'd2;        err_o = 1'b0; end
      SEG_3:     begin digit_o = 4'd3;        err_o = 1'b0; end
      SEG_4:     begin digit_o = 4'd4;        err_o = 1'b0; end
      SEG_5:     begin digit_o = 4'd5;        err_o = 1'b0; end
      SEG_6:     begin digit_o = 4'd6;        err_o = 1'b0; end
      SEG_7:     begin digit_o = 4'd7;        err_o = 1'b0; end
      SEG_8:     begin digit_o = 4'd8;        err_o = 1'b0; end
      SEG_9:     begin digit_o = 4'd9;        err_o = 1'b0; end
      SEG_BLANK: begin digit_o = DIGIT_BLANK; err_o = 1'b0; end
      default:   ;
    endcase
  end

endmodule

// File: rtl/serial_display_rx.sv
// Receiver for the 7-segment serial display link.
// Synchronizes the serial data/clock/latch lines, shifts one frame of
// 8*NUM_DIGITS bits (MSB first) and, on a latch edge with the exact bit
// count, decodes and registers every digit.
// Ports:
//   i_clk, i_reset_n   system clock, synchronous active-low reset
//   i_en               receiver enable (edge tracking continues when low)
//   i_serial_data      serial data, taken on serial clock rising edge
//   i_serial_clk       serial shift clock
//   i_serial_latch     frame commit on rising edge
//   o_digits           decoded BCD digits, hours_msb in the top nibble
//   o_dp               decimal points, same digit order
//   o_frame_stb        one-cycle pulse per committed frame
//   o_frame_err        one-cycle pulse on bad bit count or collision
//   o_seg_err          set when the last committed frame had a bad pattern
module serial_display_rx
  import display_pkg::*;
#(
  parameter int NUM_DIGITS  = 6,
  parameter int SYNC_STAGES = 2
) (
  input  logic                    i_clk,
  input  logic                    i_reset_n,
  input  logic                    i_en,
  input  logic                    i_serial_data,
  input  logic                    i_serial_clk,
  input  logic                    i_serial_latch,
  output logic [4*NUM_DIGITS-1:0] o_digits,
  output logic [NUM_DIGITS-1:0]   o_dp,
  output logic                    o_frame_stb,
  output logic                    o_frame_err,
  output logic                    o_seg_err
);

  localparam int FRAME_BITS = 8 * NUM_DIGITS;
  localparam int CNT_W      = $clog2(FRAME_BITS + 2);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_BITS);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(FRAME_BITS + 1);

  logic [SYNC_STAGES-1:0] sclk_sync_q, data_sync_q, latch_sync_q;
  logic                   sclk_hist_q, latch_hist_q;
  logic                   sclk_rise_d, latch_rise_d;
  // Edge flags and data are registered together so a shift uses the data
  // bit that travelled through the same number of flops as its clock.
  logic                   sclk_rise_q, latch_rise_q, data_q;

  logic [FRAME_BITS-1:0]   shreg_q, shreg_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [4*NUM_DIGITS-1:0] digits_q, digits_d;
  logic [NUM_DIGITS-1:0]   dp_q, dp_d;
  logic                    seg_err_q, seg_err_d;
  logic                    stb_q, stb_d;
  logic                    err_q, err_d;

  logic [4*NUM_DIGITS-1:0] dec_digits;
  logic [NUM_DIGITS-1:0]   dec_dp;
  logic [NUM_DIGITS-1:0]   dec_err;

  assign sclk_rise_d  = sclk_sync_q[SYNC_STAGES-1] & ~sclk_hist_q;
  assign latch_rise_d = latch_sync_q[SYNC_STAGES-1] & ~latch_hist_q;

  // Synchronizers and edge detectors run regardless of i_en so that
  // re-enabling never sees a stale level as a fresh edge.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      sclk_sync_q  <= '0;
      data_sync_q  <= '0;
      latch_sync_q <= '0;
      sclk_hist_q  <= 1'b0;
      latch_hist_q <= 1'b0;
      sclk_rise_q  <= 1'b0;
      latch_rise_q <= 1'b0;
      data_q       <= 1'b0;
    end else begin
      sclk_sync_q  <= {sclk_sync_q[SYNC_STAGES-2:0], i_serial_clk};
      data_sync_q  <= {data_sync_q[SYNC_STAGES-2:0], i_serial_data};
      latch_sync_q <= {latch_sync_q[SYNC_STAGES-2:0], i_serial_latch};
      sclk_hist_q  <= sclk_sync_q[SYNC_STAGES-1];
      latch_hist_q <= latch_sync_q[SYNC_STAGES-1];
      sclk_rise_q  <= sclk_rise_d;
      latch_rise_q <= latch_rise_d;
      data_q       <= data_sync_q[SYNC_STAGES-1];
    end
  end

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dec
    seg7_decode u_dec (
      .seg_i   (shreg_q[8*g +: SEG_BITS]),
      .digit_o (dec_digits[4*g +: 4]),
      .err_o   (dec_err[g])
    );
    assign dec_dp[g] = shreg_q[8*g + BIT_DP];
  end

  always_comb begin
    shreg_d   = shreg_q;
    cnt_d     = cnt_q;
    digits_d  = digits_q;
    dp_d      = dp_q;
    seg_err_d = seg_err_q;
    stb_d     = 1'b0;
    err_d     = 1'b0;
    if (i_en) begin
      if (latch_rise_q) begin
        // A shift edge landing with the latch makes the frame ambiguous,
        // so it is dropped and the frame rejected.
        cnt_d = '0;
        if (!sclk_rise_q && (cnt_q == CNT_FULL)) begin
          digits_d  = dec_digits;
          dp_d      = dec_dp;
          seg_err_d = |dec_err;
          stb_d     = 1'b1;
        end else begin
          err_d = 1'b1;
        end
      end else if (sclk_rise_q) begin
        shreg_d = {shreg_q[FRAME_BITS-2:0], data_q};
        if (cnt_q != CNT_SAT) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      shreg_q   <= '0;
      cnt_q     <= '0;
      digits_q  <= '0;
      dp_q      <= '0;
      seg_err_q <= 1'b0;
      stb_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      shreg_q   <= shreg_d;
      cnt_q     <= cnt_d;
      digits_q  <= digits_d;
      dp_q      <= dp_d;
      seg_err_q <= seg_err_d;
      stb_q     <= stb_d;
      err_q     <= err_d;
    end
  end

  assign o_digits    = digits_q;
  assign o_dp        = dp_q;
  assign o_seg_err   = seg_err_q;
  assign o_frame_stb = stb_q;
  assign o_frame_err = err_q;

endmodule
